data_generation_multi: RTL and testbench

DATA_GENERATION_MULTI -- requirements
Module: data_generation_multi

---
 rtl/data_generation_multi.sv | 144 ++++++++++++++
 tb/tb_data_generation_multi.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_generation_multi.sv
// Multi-channel stepped value generator with per-channel arm/advance strobes.
// Optional bounce mode is built only when DATA_GEN_BOUNCE_EN is defined.
module data_generation_multi #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int START = 120,
  parameter int STOP  = 136,
  parameter int STEP  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       map,
  input  logic                  restart,
  input  logic [1:0]            mode,
  output logic [N_CH-1:0]       data_en,
  output logic [N_CH*WIDTH-1:0] data,
  output logic [N_CH-1:0]       wrap,
  output logic [N_CH-1:0]       done
);

  // Channel direction (only with DATA_GEN_BOUNCE_EN):
  // state    | meaning
  // DIR_UP   | channel steps upward toward STOP
  // DIR_DOWN | bounce mode, channel steps downward toward START

  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STOP_X  = (WIDTH+1)'(STOP);
  localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);

`ifdef DATA_GEN_BOUNCE_EN
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [WIDTH:0] START_X = (WIDTH+1)'(START);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  dir_t dir_q [N_CH];
  dir_t dir_d [N_CH];
  logic bounce_sel;

  assign bounce_sel = (mode == MODE_BOUNCE);
`endif

  logic [WIDTH-1:0] val_q [N_CH];
  logic [WIDTH-1:0] val_d [N_CH];
  logic [N_CH-1:0]  en_q, en_d;
  logic [N_CH-1:0]  wrap_q, wrap_d;
  logic [N_CH-1:0]  done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= '0;
      wrap_q <= '0;
      done_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        val_q[i] <= START_V;
`ifdef DATA_GEN_BOUNCE_EN
        dir_q[i] <= DIR_UP;
`endif
      end
    end else begin
      en_q   <= en_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
      for (int i = 0; i < N_CH; i++) begin
        val_q[i] <= val_d[i];
`ifdef DATA_GEN_BOUNCE_EN
        dir_q[i] <= dir_d[i];
`endif
      end
    end
  end

  always_comb begin
    en_d   = en_q;
    wrap_d = '0;
    done_d = done_q;
    for (int i = 0; i < N_CH; i++) begin
      val_d[i] = val_q[i];
`ifdef DATA_GEN_BOUNCE_EN
      // Leaving bounce mode snaps the channel back to upward stepping.
      dir_d[i] = bounce_sel ? dir_q[i] : DIR_UP;
`endif
      if (restart) begin
        val_d[i]  = START_V;
        en_d[i]   = 1'b0;
        done_d[i] = 1'b0;
`ifdef DATA_GEN_BOUNCE_EN
        dir_d[i]  = DIR_UP;
`endif
      end else if (map[i] && !done_q[i]) begin
        if (!en_q[i]) begin
          en_d[i] = 1'b1;
        end
`ifdef DATA_GEN_BOUNCE_EN
        else if (bounce_sel && (dir_q[i] == DIR_DOWN)) begin
          if ({1'b0, val_q[i]} < (START_X + STEP_X)) begin
            dir_d[i]  = DIR_UP;
            val_d[i]  = val_q[i] + STEP_V;
            wrap_d[i] = 1'b1;
          end else begin
            val_d[i] = val_q[i] - STEP_V;
          end
        end
`endif
        else if (({1'b0, val_q[i]} + STEP_X) > STOP_X) begin
          case (mode)
            MODE_ONESHOT: begin
              done_d[i] = 1'b1;
              wrap_d[i] = 1'b1;
            end
`ifdef DATA_GEN_BOUNCE_EN
            MODE_BOUNCE: begin
              dir_d[i]  = DIR_DOWN;
              val_d[i]  = val_q[i] - STEP_V;
              wrap_d[i] = 1'b1;
            end
`endif
            default: begin
              val_d[i]  = START_V;
              wrap_d[i] = 1'b1;
            end
          endcase
        end else begin
          val_d[i] = val_q[i] + STEP_V;
        end
      end
    end
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < N_CH; i++) begin
      data[i*WIDTH +: WIDTH] = val_q[i];
    end
  end

  assign data_en = en_q;
  assign wrap    = wrap_q;
  assign done    = done_q;

endmodule

// File: tb/tb_data_generation_multi.sv
// Directed vector bench for data_generation_multi (2 channels, 120..136 step 4).
// Bounce expectations follow DATA_GEN_BOUNCE_EN as the design is built.
module tb_data_generation_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  map;
  logic        restart;
  logic [1:0]  mode;
  logic [1:0]  data_en;
  logic [15:0] data;
  logic [1:0]  wrap;
  logic [1:0]  done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_generation_multi #(
    .WIDTH(8), .N_CH(2), .START(120), .STOP(136), .STEP(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .map(map),
    .restart(restart),
    .mode(mode),
    .data_en(data_en),
    .data(data),
    .wrap(wrap),
    .done(done)
  );

  typedef struct {
    logic       rst;
    logic       rs;
    logic [1:0] md;
    logic [1:0] mp;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] en;
    logic [1:0] wr;
    logic [1:0] dn;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int rst, input int rs, input int md, input int mp,
                              input int d0, input int d1, input int en, input int wr, input int dn);
    vec_t v;
    v.rst = rst[0];
    v.rs  = rs[0];
    v.md  = md[1:0];
    v.mp  = mp[1:0];
    v.d0  = d0[7:0];
    v.d1  = d1[7:0];
    v.en  = en[1:0];
    v.wr  = wr[1:0];
    v.dn  = dn[1:0];
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input vec_t v);
    chk("data0",   idx, data[7:0],          v.d0);
    chk("data1",   idx, data[15:8],         v.d1);
    chk("data_en", idx, {6'd0, data_en},    {6'd0, v.en});
    chk("wrap",    idx, {6'd0, wrap},       {6'd0, v.wr});
    chk("done",    idx, {6'd0, done},       {6'd0, v.dn});
  endtask

  initial begin
    vec_t cur;
    reset   = 1'b1;
    restart = 1'b0;
    mode    = 2'd0;
    map     = 2'b00;

    // wrap mode: arm, climb, reload, toggled strobe, second channel, reset mid-sequence
    add(1,0,0,0, 120,120, 0,0,0);
    add(0,0,0,1, 120,120, 1,0,0);
    add(0,0,0,1, 124,120, 1,0,0);
    add(0,0,0,1, 128,120, 1,0,0);
    add(0,0,0,1, 132,120, 1,0,0);
    add(0,0,0,1, 136,120, 1,0,0);
    add(0,0,0,1, 120,120, 1,1,0);
    add(0,0,0,1, 124,120, 1,0,0);
    add(0,0,0,0, 124,120, 1,0,0);
    add(0,0,0,1, 128,120, 1,0,0);
    add(0,0,0,0, 128,120, 1,0,0);
    add(0,0,0,1, 132,120, 1,0,0);
    add(0,0,0,2, 132,120, 3,0,0);
    add(0,0,0,3, 136,124, 3,0,0);
    add(0,0,3,3, 120,128, 3,1,0);
    add(0,0,0,1, 124,128, 3,0,0);
    add(0,0,0,1, 128,128, 3,0,0);
    add(1,1,0,3, 120,120, 0,0,0);

    // one-shot: stop at the top, single pulse, ignore strobes, restart clears
    add(0,0,2,1, 120,120, 1,0,0);
    add(0,0,2,1, 124,120, 1,0,0);
    add(0,0,2,1, 128,120, 1,0,0);
    add(0,0,2,1, 132,120, 1,0,0);
    add(0,0,2,1, 136,120, 1,0,0);
    add(0,0,2,1, 136,120, 1,1,1);
    add(0,0,2,1, 136,120, 1,0,1);
    add(0,0,2,3, 136,120, 3,0,1);
    add(0,0,2,3, 136,124, 3,0,1);
    add(0,1,2,3, 120,120, 0,0,0);
    add(0,0,2,1, 120,120, 1,0,0);

    // mode 1: bounce when built in, otherwise identical to wrap
    add(1,0,1,3, 120,120, 0,0,0);
    add(0,0,1,3, 120,120, 3,0,0);
    add(0,0,1,3, 124,124, 3,0,0);
    add(0,0,1,3, 128,128, 3,0,0);
    add(0,0,1,3, 132,132, 3,0,0);
    add(0,0,1,3, 136,136, 3,0,0);
`ifdef DATA_GEN_BOUNCE_EN
    add(0,0,1,3, 132,132, 3,3,0);
    add(0,0,1,3, 128,128, 3,0,0);
    add(0,0,1,3, 124,124, 3,0,0);
    add(0,0,1,3, 120,120, 3,0,0);
    add(0,0,1,3, 124,124, 3,3,0);
    add(0,0,1,3, 128,128, 3,0,0);
    add(0,0,1,3, 132,132, 3,0,0);
    add(0,0,1,3, 136,136, 3,0,0);
    add(0,0,1,3, 132,132, 3,3,0);
    add(0,0,0,0, 132,132, 3,0,0);
    add(0,0,0,3, 136,136, 3,0,0);
    add(0,0,1,3, 132,132, 3,3,0);
    add(0,0,1,3, 128,128, 3,0,0);
`else
    add(0,0,1,3, 120,120, 3,3,0);
    add(0,0,1,3, 124,124, 3,0,0);
    add(0,0,1,3, 128,128, 3,0,0);
    add(0,0,1,3, 132,132, 3,0,0);
    add(0,0,1,3, 136,136, 3,0,0);
    add(0,0,1,3, 120,120, 3,3,0);
    add(0,0,1,3, 124,124, 3,0,0);
    add(0,0,0,0, 124,124, 3,0,0);
    add(0,0,0,3, 128,128, 3,0,0);
`endif
    add(1,1,1,3, 120,120, 0,0,0);

    foreach (vecs[k]) begin
      cur     = vecs[k];
      reset   = cur.rst;
      restart = cur.rs;
      mode    = cur.md;
      map     = cur.mp;
      @(posedge clk);
      #1;
      check_outputs(k, cur);
    end

    // registered outputs: a strobe must not show before the next edge
    reset   = 1'b0;
    restart = 1'b0;
    mode    = 2'd0;
    map     = 2'b11;
    #2;
    chk("comb_en",   900, {6'd0, data_en}, 8'd0);
    chk("comb_data", 900, data[7:0],       8'd120);
    @(posedge clk);
    #1;
    chk("arm_en",    901, {6'd0, data_en}, 8'd3);
    chk("arm_data",  901, data[15:8],      8'd120);
    @(posedge clk);
    #1;
    chk("step_data", 902, data[15:8],      8'd124);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
